// File: rtl/demux_1to9_clk_if.sv
// demux_1to9_clk_if
// Groups the beat-input handshake and the vector hand-off handshake of the
// 1-to-9 lane demultiplexer into one bundle. The producer/consumer side
// (testbench or surrounding logic) uses the master modport. The
// demultiplexer itself uses the slave modport.
interface demux_1to9_clk_if #(
    parameter int DATA_WIDTH = 8
);

    // Beat input side
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH-1:0]       in_data;
    logic [3:0]                  in_sel;
    logic                        flush;

    // Vector output side
    logic [7:0][DATA_WIDTH-1:0]  vec;
    logic [7:0]                  mask;
    logic                        out_valid;
    logic                        out_ready;

    // Status
    logic                        sel_err;

    // Environment side: offers beats, consumes vectors
    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output flush,
        output out_ready,
        input  in_ready,
        input  vec,
        input  mask,
        input  out_valid,
        input  sel_err
    );

    // Demultiplexer side
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  flush,
        input  out_ready,
        output in_ready,
        output vec,
        output mask,
        output out_valid,
        output sel_err
    );

endinterface

// File: rtl/demux_1to9_clk.sv
// demux_1to9_clk
// Routes incoming words into one of eight registered lanes (select 0..7),
// discards select 8, and hands the collected lane bank downstream once all
// eight lanes have been written or a flush is requested.
//
// Optional feature macro: DEMUX_SEL_ERR_EN
//   defined   : selects 9..15 are dropped and raise a sticky sel_err flag
//   undefined : selects 9..15 behave exactly like the discard select 8 and
//               sel_err is tied low
module demux_1to9_clk #(
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    demux_1to9_clk_if.slave  bus
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

    logic [0:0]                 state;
    logic [0:0]                 state_next;

    // Goes high at the first edge after reset releases, so that the input
    // side stays closed while reset is held and opens one cycle later.
    logic                       alive;

    logic [7:0][DATA_WIDTH-1:0] lanes;
    logic [7:0][DATA_WIDTH-1:0] lanes_next;
    logic [7:0]                 lane_mask;
    logic [7:0]                 lane_mask_next;

    logic                       accept;
    logic                       take;
    logic                       lane_hit;
    logic [7:0]                 lane_onehot;
    logic                       go_full;

`ifdef DEMUX_SEL_ERR_EN
    logic                       sel_illegal;
    logic                       err_q;
    logic                       err_next;
`endif

    // Handshake outputs come purely from registered state, so neither
    // ready nor valid has a combinational path from the opposite side.
    assign bus.in_ready  = alive && (state == COLLECT);
    assign bus.out_valid = (state == FULL);
    assign bus.vec       = lanes;
    assign bus.mask      = lane_mask;

    assign accept = bus.in_valid && bus.in_ready;
    assign take   = bus.out_valid && bus.out_ready;

    // Select decode: the top select bit clear means a real lane 0..7
    assign lane_hit    = ~bus.in_sel[3];
    assign lane_onehot = 8'b0000_0001 << bus.in_sel[2:0];

`ifdef DEMUX_SEL_ERR_EN
    assign sel_illegal = bus.in_sel[3] && (bus.in_sel[2:0] != 3'd0);
    assign bus.sel_err = err_q;
`else
    assign bus.sel_err = 1'b0;
`endif

    // Next-state and lane-bank update: writes land first, then the
    // transition decision looks at the post-write mask so a beat that
    // arrives together with flush (or completes the bank) is included.
    always_comb begin
        state_next     = state;
        lanes_next     = lanes;
        lane_mask_next = lane_mask;
        go_full        = 1'b0;
`ifdef DEMUX_SEL_ERR_EN
        err_next       = err_q;
`endif
        case (state)
            COLLECT: begin
                if (accept && lane_hit) begin
                    lanes_next[bus.in_sel[2:0]] = bus.in_data;
                    lane_mask_next              = lane_mask | lane_onehot;
                end
`ifdef DEMUX_SEL_ERR_EN
                if (accept && sel_illegal) begin
                    err_next = 1'b1;
                end
`endif
                if (lane_mask_next == 8'hFF) begin
                    go_full = 1'b1;
                end else if (bus.flush && (lane_mask_next != 8'h00)) begin
                    go_full = 1'b1;
                end
                if (go_full) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (take) begin
                    lanes_next     = '0;
                    lane_mask_next = 8'h00;
                    state_next     = COLLECT;
                end
            end
            default: begin
                lanes_next     = '0;
                lane_mask_next = 8'h00;
                state_next     = COLLECT;
            end
        endcase
    end

    // State, lane bank and mask registers; reset discards any partial or
    // pending vector immediately without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            alive     <= 1'b0;
            lanes     <= '0;
            lane_mask <= 8'h00;
        end else begin
            state     <= state_next;
            alive     <= 1'b1;
            lanes     <= lanes_next;
            lane_mask <= lane_mask_next;
        end
    end

`ifdef DEMUX_SEL_ERR_EN
    // Sticky illegal-select flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_next;
        end
    end
`endif

endmodule

// File: doc/demux_1to9_clk.md
DEMUX_1TO9_CLK -- requirements
Module: demux_1to9_clk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one lane word.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  beat offered.
REQ-005 SHALL have port in_ready  output  1  beat acceptable; accept = in_valid && in_ready.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  word to route.
REQ-007 SHALL have port in_sel  input  4  destination: 0..7 lane index, 8 discard, 9..15 illegal.
REQ-008 SHALL have port flush  input  1  emit a partially filled vector.
REQ-009 SHALL have port vec  output  8 x DATA_WIDTH  registered lane bank.
REQ-010 SHALL have port mask  output  8  bit i set = lane i written since last emit.
REQ-011 SHALL have port out_valid  output  1  vec/mask valid for hand-off.
REQ-012 SHALL have port out_ready  input  1  consumer takes vec; take = out_valid && out_ready.
REQ-013 SHALL have port sel_err  output  1  sticky illegal-select flag.

Function
REQ-014 SHALL implement two states: COLLECT (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1); both outputs decoded from registered state only.
REQ-015 In COLLECT, an accepted beat with in_sel=k (0..7) SHALL write in_data to vec[k] and set mask[k] at the next edge.
REQ-016 A write to a lane whose mask bit is already set SHALL overwrite it (last write wins), mask unchanged.
REQ-017 An accepted beat with in_sel=8 SHALL be consumed with no change to vec or mask.
REQ-018 COLLECT->FULL SHALL occur at the edge where mask becomes 8'hFF; out_valid asserts the cycle after the eighth distinct-lane accept (latency 1).
REQ-019 flush sampled high in COLLECT with the post-edge mask nonzero SHALL cause COLLECT->FULL at that edge; unwritten lanes read 0.
REQ-020 flush with the post-edge mask equal to 0 SHALL be ignored.
REQ-021 A beat accepted in the same cycle as flush SHALL be written before the transition (included in the emitted vector).
REQ-022 flush sampled in FULL SHALL be ignored.
REQ-023 In FULL, vec and mask SHALL hold stable until take.
REQ-024 On take, FULL->COLLECT at that edge; all lanes cleared to 0 and mask cleared to 0; in_ready reasserts the next cycle (no same-cycle bypass).
REQ-025 out_valid SHALL NOT depend combinationally on out_ready; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-026 While reset is high: state=COLLECT, vec all 0, mask=0, out_valid=0, sel_err=0; in_ready SHALL be 0 and SHALL rise the first cycle after reset deasserts.
REQ-027 Reset asserted mid-collection or in FULL SHALL discard the vector immediately, independent of clk.

Configuration
REQ-028 Macro DEMUX_SEL_ERR_EN defined: an accepted beat with in_sel 9..15 SHALL be dropped and set sel_err, which stays high until reset.
REQ-029 Macro DEMUX_SEL_ERR_EN undefined: in_sel 9..15 SHALL be treated exactly as in_sel=8, and sel_err SHALL be tied to 0.

Verification
REQ-030 Eight beats, sel 0..7, data 8'h10..8'h17, out_ready=0 -> out_valid rises one cycle after the eighth accept; vec[i]=8'h10+i; mask=8'hFF; in_ready=0 and vec stable for 5 held cycles.
REQ-031 Beats sel=3 data 8'hAA, then sel=3 data 8'h55, then flush -> vec[3]=8'h55, other lanes 0, mask=8'h08.
REQ-032 flush with empty bank, plus sel=8 beat data 8'hFF -> out_valid stays 0, mask=0, vec all 0.
REQ-033 FULL with out_ready=1 -> take at edge; next cycle in_ready=1, mask=0, vec all 0; a sel=0 beat data 8'h01 in that cycle lands in vec[0].
REQ-034 Five lanes written, then reset pulsed for 3 ns between edges -> mask=0, vec=0, out_valid=0 asynchronously; collection restarts clean.
REQ-035 in_sel=4'hC, data 8'h77 -> with DEMUX_SEL_ERR_EN: sel_err=1 and stays high, mask=0; without it: sel_err=0, mask=0.
